// File: rtl/adder_pkg.sv
// adder_pkg: shared width constants and the round-robin search helper.
package adder_pkg;
    localparam int ADD_W   = 5;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Scans downward so the lowest rotated offset from ptr wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr, input int n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                j = (j >= n) ? j - n : j;
                if (valid[j]) begin
                    p.found = 1'b1;
                    p.idx   = 3'(j);
                end
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/adder.sv
// adder: unsigned ADD_W-bit adder with carry out.
module adder
    import adder_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = a + b;
endmodule

// File: rtl/rr_pick_onehot.sv
// rr_pick_onehot: combinational round-robin picker returning one-hot grant and index.
module rr_pick_onehot
    import adder_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);
    pick_t w_pick;
    assign w_pick  = rr_pick(MAX_REQ'(i_valid), 3'(i_ptr), NUM_REQ);
    assign o_any   = w_pick.found;
    assign o_idx   = ID_W'(w_pick.idx);
    assign o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
endmodule

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one adder with a registered valid/ready result.
// Optional grant counter port grant_cnt enabled by ADDER_RR_ARBITER_STATS_EN.
module adder_rr_arbiter
    import adder_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ADD_W-1:0] req_a,
    input  logic [NUM_REQ*ADD_W-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ADD_W-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [ID_W-1:0]          rsp_id
`ifdef ADDER_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]              grant_cnt
`endif
);
    logic [ID_W-1:0]    r_ptr;
    logic               r_valid;
    logic [ADD_W-1:0]   r_sum;
    logic               r_cout;
    logic [ID_W-1:0]    r_id;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_next_ptr;
    logic               w_any;
    logic               w_can_accept;
    logic               w_xfer;
    logic [ADD_W-1:0]   w_a;
    logic [ADD_W-1:0]   w_b;
    logic [ADD_W-1:0]   w_sum;
    logic               w_cout;

    rr_pick_onehot #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    adder u_adder (
        .a    (w_a),
        .b    (w_b),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_can_accept = !r_valid || rsp_ready;
    assign w_xfer       = w_can_accept && w_any;
    assign req_ready    = w_can_accept ? w_grant : '0;
    assign w_a          = req_a[w_idx*ADD_W +: ADD_W];
    assign w_b          = req_b[w_idx*ADD_W +: ADD_W];
    assign w_next_ptr   = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign rsp_valid    = r_valid;
    assign rsp_sum      = r_sum;
    assign rsp_cout     = r_cout;
    assign rsp_id       = r_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= '0;
        end else if (w_xfer) begin
            r_ptr   <= w_next_ptr;
            r_valid <= 1'b1;
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_id    <= w_idx;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef ADDER_RR_ARBITER_STATS_EN
    logic [15:0] r_cnt;
    assign grant_cnt = r_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_xfer)
            r_cnt <= r_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed and randomized checks against a behavioural model.
module tb_adder_rr_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*5-1:0] req_a = '0;
    logic [N*5-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [4:0]     rsp_sum;
    logic           rsp_cout;
    logic [1:0]     rsp_id;
`ifdef ADDER_RR_ARBITER_STATS_EN
    logic [15:0]    grant_cnt;
`endif

    int checks = 0;
    int failures = 0;

    bit       m_on = 0;
    bit       m_v = 0;
    int       m_s = 0;
    int       m_c = 0;
    int       m_id = 0;
    int       m_ptr = 0;
    int       m_cnt = 0;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
`ifdef ADDER_RR_ARBITER_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .rsp_id    (rsp_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*5 +: 5] = 5'(a);
        req_b[i*5 +: 5] = 5'(b);
    endtask

    // Model: grant is the first valid requester scanning from ptr with wraparound.
    always begin
        int g;
        int sv;
        bit r_s;
        logic [N-1:0] er;
        @(negedge clk);
        g = -1;
        if (!m_v || rsp_ready)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        if (m_on) begin
            chk("m_req_ready", 32'(req_ready), 32'(er));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_v));
            chk("m_rsp_sum", 32'(rsp_sum), m_s);
            chk("m_rsp_cout", 32'(rsp_cout), m_c);
            chk("m_rsp_id", 32'(rsp_id), m_id);
`ifdef ADDER_RR_ARBITER_STATS_EN
            chk("m_grant_cnt", 32'(grant_cnt), m_cnt % 65536);
`endif
        end
        r_s = rst;
        @(posedge clk);
        if (r_s) begin
            m_on = 1; m_v = 0; m_s = 0; m_c = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
        end else if (g >= 0) begin
            sv = int'(req_a[g*5 +: 5]) + int'(req_b[g*5 +: 5]);
            m_s = sv % 32;
            m_c = sv / 32;
            m_id = g;
            m_v = 1;
            m_ptr = (g + 1) % N;
            m_cnt++;
        end else if (rsp_ready) begin
            m_v = 0;
        end
    end

    initial begin
        int fa[N];
        int fb[N];
        step();
        step();
        rst = 1'b0;

        req_valid = 4'b0001;
        set_op(0, 31, 1);
        rsp_ready = 1'b1;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_sum", 32'(rsp_sum), 0);
        chk("single_cout", 32'(rsp_cout), 1);
        chk("single_id", 32'(rsp_id), 0);

        do_reset();
        for (int i = 0; i < N; i++) begin
            fa[i] = (7 * i + 3) % 32;
            fb[i] = (9 * i + 20) % 32;
            set_op(i, fa[i], fb[i]);
        end
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fair_id", 32'(rsp_id), k % N);
            chk("fair_sum", 32'(rsp_sum), (fa[k % N] + fb[k % N]) % 32);
            chk("fair_cout", 32'(rsp_cout), (fa[k % N] + fb[k % N]) / 32);
        end
        req_valid = '0;

        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 10, 7);
        step();
        set_op(0, 3, 4);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_sum", 32'(rsp_sum), 17);
            chk("bp_cout", 32'(rsp_cout), 0);
            chk("bp_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        chk("bp_release_valid", 32'(rsp_valid), 1);
        chk("bp_release_sum", 32'(rsp_sum), 7);

        do_reset();
        req_valid = 4'b0001;
        step();
        chk("skip_id0", 32'(rsp_id), 0);
        req_valid = 4'b1000;
        step();
        chk("skip_id3", 32'(rsp_id), 3);
        req_valid = 4'b0101;
        step();
        chk("skip_id0b", 32'(rsp_id), 0);
        step();
        chk("skip_id2", 32'(rsp_id), 2);
        req_valid = '0;

        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 20, 20);
        step();
        req_valid = '0;
        chk("mid_pre_valid", 32'(rsp_valid), 1);
        do_reset();
        chk("mid_valid", 32'(rsp_valid), 0);
        chk("mid_sum", 32'(rsp_sum), 0);
        chk("mid_cout", 32'(rsp_cout), 0);
        chk("mid_id", 32'(rsp_id), 0);
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        step();
        chk("mid_next_id", 32'(rsp_id), 0);
        req_valid = '0;

        for (int k = 0; k < 3000; k++) begin
            req_valid = 4'($urandom);
            req_a = 20'($urandom);
            req_b = 20'($urandom);
            rsp_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(99) == 0);
            step();
        end
        rst = 1'b0;
        req_valid = '0;

`ifdef ADDER_RR_ARBITER_STATS_EN
        do_reset();
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        repeat (70000) step();
        req_valid = '0;
        chk("stats_wrap", 32'(grant_cnt), 4464);
`endif

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
